// File: rtl/sd_sector_loader.sv
// Streams a run of consecutive SD sectors from the SPI controller into byte-wide on-chip memory.
// Define SD_LOADER_CHECKSUM_EN to add a 16-bit byte sum output checked against expect_sum.
module sd_sector_loader #(
  parameter int unsigned MEM_ADDR_W      = 18,
  parameter int unsigned BYTE_ADDRESSING = 0,
  parameter int unsigned SECTOR_BYTES    = 512
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [31:0]           base_sector,
  input  logic [15:0]           sector_count,
  input  logic [MEM_ADDR_W-1:0] mem_base,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  input  logic                  sd_ready,
  output logic                  sd_rd,
  output logic [31:0]           sd_address,
  input  logic [7:0]            sd_dout,
  input  logic                  sd_byte_available,
  output logic                  mem_we,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_wdata
`ifdef SD_LOADER_CHECKSUM_EN
  ,
  input  logic [15:0]           expect_sum,
  output logic [15:0]           checksum
`endif
);

  localparam int unsigned     CntW    = $clog2(SECTOR_BYTES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(SECTOR_BYTES - 1);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StWaitReady  = 3'd1;
  localparam logic [2:0] StWaitAccept = 3'd2;
  localparam logic [2:0] StReceive    = 3'd3;
  localparam logic [2:0] StSectorEnd  = 3'd4;
  localparam logic [2:0] StFinish     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  busy_q, busy_d, done_q, done_d, error_q, error_d, rd_q, rd_d;
  logic [31:0]           addr_q, addr_d, sector_q, sector_d;
  logic [15:0]           remain_q, remain_d;
  logic [MEM_ADDR_W-1:0] cur_addr_q, cur_addr_d, waddr_q, waddr_d;
  logic [CntW-1:0]       byte_cnt_q, byte_cnt_d;
  logic                  we_q, we_d;
  logic [7:0]            wdata_q, wdata_d, dout_q;
  logic                  avail_q, avail_qq;
  logic                  byte_edge, sum_bad;
  logic [31:0]           sector_addr;

  // Strobe and data are sampled together so dout_q holds the byte belonging to the edge.
  assign byte_edge   = avail_q & ~avail_qq;
  assign sector_addr = (BYTE_ADDRESSING != 0) ? {sector_q[22:0], 9'd0} : sector_q;

`ifdef SD_LOADER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d, expect_q, expect_d;
  assign sum_bad  = (sum_q != expect_q);
  assign checksum = sum_q;
`else
  assign sum_bad = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    error_d    = error_q;
    rd_d       = rd_q;
    addr_d     = addr_q;
    sector_d   = sector_q;
    remain_d   = remain_q;
    cur_addr_d = cur_addr_q;
    waddr_d    = waddr_q;
    byte_cnt_d = byte_cnt_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
`ifdef SD_LOADER_CHECKSUM_EN
    sum_d      = sum_q;
    expect_d   = expect_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          error_d = 1'b0;
`ifdef SD_LOADER_CHECKSUM_EN
          sum_d    = 16'd0;
          expect_d = expect_sum;
`endif
          if (sector_count == 16'd0) begin
            state_d = StFinish;
            done_d  = 1'b1;
          end else begin
            busy_d     = 1'b1;
            sector_d   = base_sector;
            remain_d   = sector_count;
            cur_addr_d = mem_base;
            state_d    = StWaitReady;
          end
        end
      end
      StWaitReady: begin
        if (sd_ready) begin
          rd_d    = 1'b1;
          addr_d  = sector_addr;
          state_d = StWaitAccept;
        end
      end
      StWaitAccept: begin
        if (!sd_ready) begin
          rd_d       = 1'b0;
          byte_cnt_d = '0;
          state_d    = StReceive;
        end
      end
      StReceive: begin
        if (byte_edge) begin
          we_d       = 1'b1;
          wdata_d    = dout_q;
          waddr_d    = cur_addr_q;
          cur_addr_d = cur_addr_q + MEM_ADDR_W'(1);
          byte_cnt_d = byte_cnt_q + CntW'(1);
`ifdef SD_LOADER_CHECKSUM_EN
          sum_d      = sum_q + 16'(dout_q);
`endif
          if (byte_cnt_q == LastCnt) state_d = StSectorEnd;
        end else if (sd_ready) begin
          // Controller went idle early: the sector was cut short.
          error_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = StFinish;
        end
      end
      StSectorEnd: begin
        if (byte_edge) error_d = 1'b1;
        if (sd_ready) begin
          remain_d = remain_q - 16'd1;
          sector_d = sector_q + 32'd1;
          if (remain_q == 16'd1) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StFinish;
            if (sum_bad) error_d = 1'b1;
          end else begin
            state_d = StWaitReady;
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      rd_q       <= 1'b0;
      addr_q     <= '0;
      sector_q   <= '0;
      remain_q   <= '0;
      cur_addr_q <= '0;
      waddr_q    <= '0;
      byte_cnt_q <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      dout_q     <= '0;
      avail_q    <= 1'b0;
      avail_qq   <= 1'b0;
`ifdef SD_LOADER_CHECKSUM_EN
      sum_q      <= '0;
      expect_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      rd_q       <= rd_d;
      addr_q     <= addr_d;
      sector_q   <= sector_d;
      remain_q   <= remain_d;
      cur_addr_q <= cur_addr_d;
      waddr_q    <= waddr_d;
      byte_cnt_q <= byte_cnt_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      dout_q     <= sd_dout;
      avail_q    <= sd_byte_available;
      avail_qq   <= avail_q;
`ifdef SD_LOADER_CHECKSUM_EN
      sum_q      <= sum_d;
      expect_q   <= expect_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign sd_rd      = rd_q;
  assign sd_address = addr_q;
  assign mem_we     = we_q;
  assign mem_addr   = waddr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_sd_sector_loader.sv
// Bench for sd_sector_loader: block-mode/18-bit and byte-mode/9-bit instances share one
// controller model; writes and addresses are checked against a queue-based reference.
module tb_sd_sector_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_sector = '0;
  logic [15:0] sector_count = '0;
  logic [17:0] mem_base = '0;
  logic        sd_ready = 1'b1;
  logic [7:0]  sd_dout = '0;
  logic        sd_byte_available = 1'b0;

  logic        busy_a, done_a, error_a, rd_a, we_a;
  logic [31:0] addr_a;
  logic [17:0] maddr_a;
  logic [7:0]  wdata_a;
  logic        busy_b, done_b, error_b, rd_b, we_b;
  logic [31:0] addr_b;
  logic [8:0]  maddr_b;
  logic [7:0]  wdata_b;
`ifdef SD_LOADER_CHECKSUM_EN
  logic [15:0] expect_sum = '0;
  logic [15:0] sum_a, sum_b;
`endif

  int n_assert = 0;
  int n_fail = 0;

  sd_sector_loader #(.MEM_ADDR_W(18), .BYTE_ADDRESSING(0), .SECTOR_BYTES(512)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_sector(base_sector),
    .sector_count(sector_count), .mem_base(mem_base), .busy(busy_a), .done(done_a),
    .error(error_a), .sd_ready(sd_ready), .sd_rd(rd_a), .sd_address(addr_a),
    .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .mem_we(we_a),
    .mem_addr(maddr_a), .mem_wdata(wdata_a)
`ifdef SD_LOADER_CHECKSUM_EN
    , .expect_sum(expect_sum), .checksum(sum_a)
`endif
  );

  sd_sector_loader #(.MEM_ADDR_W(9), .BYTE_ADDRESSING(1), .SECTOR_BYTES(512)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start), .base_sector(base_sector),
    .sector_count(sector_count), .mem_base(mem_base[8:0]), .busy(busy_b), .done(done_b),
    .error(error_b), .sd_ready(sd_ready), .sd_rd(rd_b), .sd_address(addr_b),
    .sd_dout(sd_dout), .sd_byte_available(sd_byte_available), .mem_we(we_b),
    .mem_addr(maddr_b), .mem_wdata(wdata_b)
`ifdef SD_LOADER_CHECKSUM_EN
    , .expect_sum(expect_sum), .checksum(sum_b)
`endif
  );

  always #5 clk = ~clk;

  // Observed traffic
  logic [17:0] wa_q[$];
  logic [8:0]  wb_q[$];
  logic [7:0]  wd_q[$], wdb_q[$];
  logic [31:0] got_a[$], got_b[$];
  logic [7:0]  exp_data[$];
  int          done_cnt = 0, rd_rise = 0, proto_viol = 0, pos = 0;
  logic        ready_at_pos = 1'b1, rd_prev = 1'b0;

  always @(posedge clk) ready_at_pos <= sd_ready;

  always @(negedge clk) begin
    if (we_a) begin wa_q.push_back(maddr_a); wd_q.push_back(wdata_a); end
    if (we_b) begin wb_q.push_back(maddr_b); wdb_q.push_back(wdata_b); end
    if (done_a) done_cnt++;
    if (done_a && busy_a) proto_viol++;
    if (rd_a && !rd_prev) rd_rise++;
    rd_prev = rd_a;
    // A read request may only be visible if the controller was ready at the last edge.
    if (rd_a && !ready_at_pos) proto_viol++;
    if (rd_b !== rd_a || done_b !== done_a || busy_b !== busy_a) proto_viol++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int hold);
    sd_dout = v;
    sd_byte_available = 1'b1;
    repeat (hold) @(negedge clk);
    sd_byte_available = 1'b0;
    sd_dout = 8'($urandom);
    repeat (2) @(negedge clk);
  endtask

  task automatic serve_sector(input int nbytes, input int hold, input bit spurious,
                              output bit ok);
    int t;
    t = 0;
    while (!rd_a && t < 100) begin @(negedge clk); t++; end
    ok = rd_a;
    if (!ok) return;
    got_a.push_back(addr_a);
    got_b.push_back(addr_b);
    @(negedge clk);
    sd_ready = 1'b0;
    for (int i = 0; i < nbytes; i++) begin
      if (spurious && i == 100) begin
        start = 1'b1; base_sector = 32'hDEAD_BEEF; sector_count = 16'd9; mem_base = 18'h5;
      end
      send_byte(exp_data[pos], hold);
      start = 1'b0;
      pos++;
    end
    repeat (4) @(negedge clk);
    sd_ready = 1'b1;
  endtask

  task automatic run_load(input string tag, input logic [31:0] base, input int cnt,
                          input logic [17:0] mbase, input int short_n, input int hold,
                          input int mode, input bit spurious, input bit bad_sum);
    int total, nsec, t, bad;
    logic [15:0] msum;
    logic [31:0] sec;
    logic [7:0]  v;
    bit exp_err, ok;
    nsec  = (short_n != 0) ? 1 : cnt;
    total = (short_n != 0) ? short_n : cnt * 512;
    exp_data.delete(); wa_q.delete(); wb_q.delete(); wd_q.delete(); wdb_q.delete();
    got_a.delete(); got_b.delete();
    done_cnt = 0; rd_rise = 0; proto_viol = 0; pos = 0; msum = '0;
    for (int i = 0; i < total; i++) begin
      v = (mode == 0) ? 8'(i) : (mode == 2) ? 8'hFF : 8'($urandom);
      exp_data.push_back(v);
      msum = msum + 16'(v);
    end
    exp_err = (short_n != 0);
`ifdef SD_LOADER_CHECKSUM_EN
    expect_sum = bad_sum ? ~msum : msum;
    exp_err = exp_err | bad_sum;
`endif
    base_sector = base; sector_count = 16'(cnt); mem_base = mbase; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ":busy_after_start"}, 64'(busy_a), 64'd1);
    chk({tag, ":error_cleared"}, 64'(error_a), 64'd0);
    for (int s = 0; s < nsec; s++) begin
      serve_sector((short_n != 0) ? short_n : 512, hold, spurious && s == 0, ok);
      if (!ok) break;
    end
    t = 0;
    while (done_cnt == 0 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    chk({tag, ":wr_count_a"}, 64'(wa_q.size()), 64'(total));
    chk({tag, ":wr_count_b"}, 64'(wb_q.size()), 64'(total));
    bad = 0;
    for (int k = 0; k < wa_q.size() && k < total; k++)
      if (wa_q[k] !== 18'(mbase + 18'(k)) || wd_q[k] !== exp_data[k]) bad++;
    chk({tag, ":wr_bad_a"}, 64'(bad), 64'd0);
    bad = 0;
    for (int k = 0; k < wb_q.size() && k < total; k++)
      if (wb_q[k] !== 9'(mbase + 18'(k)) || wdb_q[k] !== exp_data[k]) bad++;
    chk({tag, ":wr_bad_b"}, 64'(bad), 64'd0);
    chk({tag, ":rd_count"}, 64'(got_a.size()), 64'(nsec));
    bad = 0;
    for (int j = 0; j < got_a.size(); j++) begin
      sec = base + 32'(j);
      if (got_a[j] !== sec || got_b[j] !== (sec << 9)) bad++;
    end
    chk({tag, ":sd_address_bad"}, 64'(bad), 64'd0);
    chk({tag, ":rd_pulses"}, 64'(rd_rise), 64'(nsec));
    chk({tag, ":done_cycles"}, 64'(done_cnt), 64'd1);
    chk({tag, ":protocol"}, 64'(proto_viol), 64'd0);
    chk({tag, ":error_a"}, 64'(error_a), 64'(exp_err));
    chk({tag, ":error_b"}, 64'(error_b), 64'(exp_err));
    chk({tag, ":busy_end"}, 64'(busy_a), 64'd0);
`ifdef SD_LOADER_CHECKSUM_EN
    chk({tag, ":checksum"}, 64'(sum_a), 64'(msum));
`endif
  endtask

  initial begin
    int wr_before;
    bit ok;
    // Reset state
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs_a", {busy_a, done_a, error_a, rd_a, addr_a, we_a, maddr_a, wdata_a}, 0);
    chk("reset_outputs_b", {busy_b, done_b, error_b, rd_b, addr_b, we_b, maddr_b, wdata_b}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_busy", 64'(busy_a), 64'd0);

    run_load("single", 32'h10, 1, 18'h0, 0, 1, 0, 1'b0, 1'b0);
    run_load("multi", 32'h3, 3, 18'h100, 0, int'($urandom_range(1, 3)), 1, 1'b1, 1'b0);
    run_load("hold3_wrap", 32'h1, 1, 18'h1F0, 0, 3, 1, 1'b0, 1'b0);
    run_load("short", 32'h20, 1, 18'h40, 300, 1, 1, 1'b0, 1'b0);
    chk("short_error_sticky", 64'(error_a), 64'd1);

    // Zero-length load: done on the cycle after start; a start during done is dropped.
    rd_rise = 0; done_cnt = 0;
    base_sector = 32'h55; sector_count = 16'd0; mem_base = '0; start = 1'b1;
    @(negedge clk);
    chk("zero:done", 64'(done_a), 64'd1);
    chk("zero:busy", 64'(busy_a), 64'd0);
    chk("zero:error", 64'(error_a), 64'd0);
    sector_count = 16'd1;
    @(negedge clk);
    start = 1'b0;
    chk("zero:done_one_cycle", 64'(done_a), 64'd0);
    repeat (10) @(negedge clk);
    chk("zero:no_rd", 64'(rd_rise), 64'd0);
    chk("zero:start_in_done_ignored", 64'(busy_a), 64'd0);

    run_load("good_after_short", 32'h21, 1, 18'h0, 0, 2, 1, 1'b0, 1'b0);
    run_load("sector_wrap", 32'hFFFF_FFFF, 2, 18'h3FF00, 0, 1, 1, 1'b0, 1'b0);

    // Reset mid-receive with strobes still toggling
    base_sector = 32'h7; sector_count = 16'd2; mem_base = 18'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rd_rise = 0;
    begin
      int t;
      t = 0;
      while (!rd_a && t < 100) begin @(negedge clk); t++; end
      ok = rd_a;
    end
    chk("abort:rd_seen", 64'(ok), 64'd1);
    @(negedge clk);
    sd_ready = 1'b0;
    for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1);
    wr_before = wa_q.size();
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
    chk("abort:outputs_a", {busy_a, done_a, error_a, rd_a, addr_a, we_a, maddr_a, wdata_a}, 0);
    chk("abort:outputs_b", {busy_b, done_b, error_b, rd_b, addr_b, we_b, maddr_b, wdata_b}, 0);
    chk("abort:no_writes", 64'(wa_q.size()), 64'(wr_before));
    reset_n = 1'b1;
    sd_ready = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort:idle_busy", 64'(busy_a), 64'd0);
    chk("abort:no_new_rd", 64'(rd_rise), 64'd1);

`ifdef SD_LOADER_CHECKSUM_EN
    run_load("sum_ok", 32'h40, 1, 18'h0, 0, 1, 2, 1'b0, 1'b0);
    run_load("sum_bad", 32'h41, 1, 18'h0, 0, 1, 2, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
